// File: rtl/sdram_port_pkg.sv
// Shared types and default timing for the toggle-handshake SDRAM port responder.
package sdram_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ACT,
    ST_CAS,
    ST_DONE,
    ST_REFRESH
  } state_e;

  localparam int WORD_W          = 16;
  localparam int CNT_W           = 8;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_T_RCD       = 2;
  localparam int DEF_CAS_LAT     = 2;
  localparam int DEF_REFRESH_INT = 1024;
  localparam int DEF_T_RFC       = 4;

  // Request fields captured at acceptance; the word index is held separately.
  typedef struct packed {
    logic              req;
    logic              we;
    logic [1:0]        ds;
    logic [WORD_W-1:0] d;
    logic              a0;
  } req_s;

  function automatic logic [7:0] byte_sel(input logic [WORD_W-1:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/sdram_port_bram.sv
// Single-port 16-bit word array with two byte enables and a 1-cycle registered read.
module sdram_port_bram
  import sdram_port_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [1:0]        be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem [2**AW];

  // No reset: contents survive a port reset, and rdata only matters after a read.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        if (be_i[0]) mem[addr_i][7:0]  <= wdata_i[7:0];
        if (be_i[1]) mem[addr_i][15:8] <= wdata_i[15:8];
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/sdram_port_responder.sv
// Responder end of the toggle-handshake memory port: SDRAM-like timing over an on-chip array.
module sdram_port_responder
  import sdram_port_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int T_RCD        = DEF_T_RCD,
  parameter int CAS_LAT      = DEF_CAS_LAT,
  parameter int REFRESH_INT  = DEF_REFRESH_INT,
  parameter int T_RFC        = DEF_T_RFC,
  parameter int ALIGN_CLKREF = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clkref,
  input  logic              port_req,
  output logic              port_ack,
  input  logic [ADDR_W-1:0] port_a,
  input  logic [1:0]        port_ds,
  input  logic              port_we,
  input  logic [WORD_W-1:0] port_d,
  output logic [7:0]        port_q,
  output logic              busy
);

  localparam int WA_W = ADDR_W - 1;
  localparam int RC_W = $clog2(REFRESH_INT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RC_W-1:0]   rcnt_q;
  logic              rfsh_due_q;
  logic              req_q, clkref_q, ack_q;
  logic [7:0]        q_q;
  req_s              lat_q;
  logic [WA_W-1:0]   wa_q;

  logic              pending, clkref_rise, rfsh_wrap, rfsh_due;
  logic              accept, rfsh_take, done, mem_en;
  logic [WORD_W-1:0] mem_rdata;

  // req passes through one register before it is compared; that cycle is part
  // of the 2+T_RCD+CAS_LAT request-to-ack latency.
  assign pending     = req_q != ack_q;
  assign clkref_rise = clkref & ~clkref_q;
  assign rfsh_wrap   = rcnt_q == RC_W'(REFRESH_INT - 1);
  assign rfsh_due    = rfsh_due_q | rfsh_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rfsh_due) begin
          state_d = ST_REFRESH;
          cnt_d   = CNT_W'(T_RFC - 1);
        end else if (pending) begin
          state_d = (ALIGN_CLKREF != 0) ? ST_SYNC : ST_ACT;
          cnt_d   = CNT_W'(T_RCD - 1);
        end
      end
      ST_SYNC: begin
        if (clkref_rise) begin
          state_d = ST_ACT;
          cnt_d   = CNT_W'(T_RCD - 1);
        end
      end
      ST_ACT: begin
        if (cnt_q == '0) begin
          state_d = ST_CAS;
          cnt_d   = CNT_W'(CAS_LAT - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CAS: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_REFRESH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = state_q != ST_IDLE;
    rfsh_take = (state_q == ST_IDLE) && rfsh_due;
    accept    = (state_q == ST_IDLE) && !rfsh_due && pending;
    done      = state_q == ST_DONE;
    // Array is touched only on the ACT->CAS edge: writes commit, reads issue.
    mem_en    = (state_q == ST_ACT) && (cnt_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q      <= 1'b0;
      clkref_q   <= 1'b0;
      rcnt_q     <= '0;
      rfsh_due_q <= 1'b0;
      ack_q      <= 1'b0;
      q_q        <= 8'h00;
      lat_q      <= '0;
      wa_q       <= '0;
    end else begin
      req_q      <= port_req;
      clkref_q   <= clkref;
      rcnt_q     <= rfsh_wrap ? '0 : rcnt_q + 1'b1;
      rfsh_due_q <= rfsh_due & ~rfsh_take;
      if (accept) begin
        lat_q.req <= req_q;
        lat_q.we  <= port_we;
        lat_q.ds  <= port_ds;
        lat_q.d   <= port_d;
        lat_q.a0  <= port_a[0];
        wa_q      <= port_a[ADDR_W-1:1];
      end
      if (done) begin
        ack_q <= lat_q.req;
        if (!lat_q.we) q_q <= byte_sel(mem_rdata, lat_q.a0);
      end
    end
  end

  assign port_ack = ack_q;
  assign port_q   = q_q;

  sdram_port_bram #(.AW(WA_W)) u_bram (
    .clk     (clk),
    .en_i    (mem_en),
    .we_i    (lat_q.we),
    .be_i    (lat_q.ds),
    .addr_i  (wa_q),
    .wdata_i (lat_q.d),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_sdram_port_responder.sv
// Directed checks of the SDRAM port responder: timing, refresh, toggle parity, reset, random traffic.
module tb_sdram_port_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic        req [3];
  logic        we  [3];
  logic [15:0] a   [3];
  logic [15:0] d   [3];
  logic [1:0]  ds  [3];
  logic        ack [3];
  logic        busy[3];
  logic [7:0]  q   [3];
  logic        cref = 1'b0;
  int          cref_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  mdl [64];

  // 12-cycle phi2 reference, updated away from both clock edges.
  always @(posedge clk) begin
    #2;
    cref_cnt = (cref_cnt == 11) ? 0 : cref_cnt + 1;
    cref     = cref_cnt < 6;
  end

  // 0: no alignment, 1: clkref aligned, 2: fast refresh
  for (genvar g = 0; g < 3; g++) begin : g_dut
    sdram_port_responder #(
      .ADDR_W(16), .T_RCD(2), .CAS_LAT(2),
      .REFRESH_INT(g == 2 ? 16 : 1024), .T_RFC(4),
      .ALIGN_CLKREF(g == 1 ? 1 : 0)
    ) u_dut (
      .clk(clk), .reset(rst[g]), .clkref(g == 1 ? cref : 1'b0),
      .port_req(req[g]), .port_ack(ack[g]), .port_a(a[g]), .port_ds(ds[g]),
      .port_we(we[g]), .port_d(d[g]), .port_q(q[g]), .busy(busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic access(input int i, input logic wr, input logic [15:0] addr,
                        input logic [1:0] be, input logic [15:0] data, output logic [7:0] qv);
    int n;
    we[i] = wr; a[i] = addr; ds[i] = be; d[i] = data;
    req[i] = !req[i];
    n = 0;
    do begin @(negedge clk); n++; end while (ack[i] !== req[i] && n < 40);
    chk("ack", 32'(ack[i]), 32'(req[i]));
    qv = q[i];
  endtask

  initial begin
    logic [7:0]  qv, b;
    logic [15:0] addr;
    logic [1:0]  be;
    logic        wr;
    int          n;
    rst = '{1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; a[i] = '0; d[i] = '0; ds[i] = '0;
    end
    tick(3);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ack", 32'(ack[i]), 32'(1'b0));
      chk("rst_q", 32'(q[i]), 32'(8'h00));
      chk("rst_busy", 32'(busy[i]), 32'(1'b0));
    end
    rst = '{1'b0, 1'b0, 1'b0};

    // Refresh tie: refresh counter is 15 after the 15th edge; toggle in that cycle.
    tick(15);
    we[2] = 1'b1; a[2] = 16'h0040; ds[2] = 2'b11; d[2] = 16'h3C3C; req[2] = 1'b1;
    tick(1);
    chk("c3_busy_rfsh", 32'(busy[2]), 32'(1'b1));
    tick(9);
    chk("c3_ack_early", 32'(ack[2]), 32'(1'b0));
    tick(1);
    chk("c3_ack", 32'(ack[2]), 32'(1'b1));
    access(2, 1'b0, 16'h0041, 2'b00, 16'h0000, qv);
    chk("c3_q", 32'(qv), 32'(8'h3C));

    // Clkref alignment: toggle just after a rise, ACT waits for the next one.
    n = 0;
    while (cref_cnt != 0 && n < 30) begin @(negedge clk); n++; end
    tick(1);
    we[1] = 1'b1; a[1] = 16'h0100; ds[1] = 2'b11; d[1] = 16'h4242; req[1] = 1'b1;
    tick(2);
    chk("c2_busy_sync", 32'(busy[1]), 32'(1'b1));
    tick(6);
    chk("c2_busy_mid", 32'(busy[1]), 32'(1'b1));
    tick(8);
    chk("c2_ack_early", 32'(ack[1]), 32'(1'b0));
    chk("c2_busy_late", 32'(busy[1]), 32'(1'b1));
    tick(1);
    chk("c2_ack", 32'(ack[1]), 32'(1'b1));
    chk("c2_idle", 32'(busy[1]), 32'(1'b0));
    access(1, 1'b0, 16'h0101, 2'b00, 16'h0000, qv);
    chk("c2_q", 32'(qv), 32'(8'h42));

    // Basic latency and byte lanes.
    access(0, 1'b1, 16'h1234, 2'b10, 16'h7E7E, qv);
    we[0] = 1'b1; a[0] = 16'h1234; ds[0] = 2'b01; d[0] = 16'hA5A5; req[0] = !req[0];
    tick(2);
    chk("c1_busy", 32'(busy[0]), 32'(1'b1));
    tick(4);
    chk("c1_ack_early", 32'(ack[0]), 32'(!req[0]));
    tick(1);
    chk("c1_ack", 32'(ack[0]), 32'(req[0]));
    access(0, 1'b0, 16'h1234, 2'b00, 16'h0000, qv);
    chk("c1_q_lo", 32'(qv), 32'(8'hA5));
    access(0, 1'b0, 16'h1235, 2'b00, 16'h0000, qv);
    chk("c1_q_hi", 32'(qv), 32'(8'h7E));

    // Two extra toggles during an access: one ack only.
    we[0] = 1'b0; a[0] = 16'h1234; req[0] = !req[0];
    tick(2); req[0] = !req[0];
    tick(1); req[0] = !req[0];
    n = 0;
    do begin @(negedge clk); n++; end while (ack[0] !== req[0] && n < 40);
    chk("c4_ack", 32'(ack[0]), 32'(req[0]));
    chk("c4_q", 32'(qv == qv ? q[0] : 8'h00), 32'(8'hA5));
    tick(12);
    chk("c4_no_extra", 32'(ack[0]), 32'(req[0]));
    chk("c4_idle", 32'(busy[0]), 32'(1'b0));

    // Three extra toggles: a second access with the latest inputs.
    we[0] = 1'b0; a[0] = 16'h1235; req[0] = !req[0];
    tick(2); req[0] = !req[0];
    tick(1); req[0] = !req[0];
    tick(1);
    we[0] = 1'b1; a[0] = 16'h0020; ds[0] = 2'b11; d[0] = 16'h9696; req[0] = !req[0];
    n = 0;
    do begin @(negedge clk); n++; end while (ack[0] === req[0] && n < 40);
    n = 0;
    while (ack[0] === req[0] && n < 40) begin @(negedge clk); n++; end
    chk("c4b_ack1", 32'(ack[0]), 32'(!req[0]));
    chk("c4b_q1", 32'(q[0]), 32'(8'h7E));
    n = 0;
    while (ack[0] !== req[0] && n < 40) begin @(negedge clk); n++; end
    chk("c4b_ack2", 32'(ack[0]), 32'(req[0]));
    access(0, 1'b0, 16'h0021, 2'b00, 16'h0000, qv);
    chk("c4b_q2", 32'(qv), 32'(8'h96));

    // Reset during CAS keeps the committed write; reset during ACT loses it.
    access(0, 1'b1, 16'h0010, 2'b11, 16'h1111, qv);
    we[0] = 1'b1; a[0] = 16'h0010; ds[0] = 2'b01; d[0] = 16'h2222; req[0] = !req[0];
    tick(5);
    rst[0] = 1'b1;
    #1;
    chk("c5_rst_ack", 32'(ack[0]), 32'(1'b0));
    chk("c5_rst_q", 32'(q[0]), 32'(8'h00));
    chk("c5_rst_busy", 32'(busy[0]), 32'(1'b0));
    @(negedge clk);
    req[0] = 1'b0; rst[0] = 1'b0;
    access(0, 1'b0, 16'h0010, 2'b00, 16'h0000, qv);
    chk("c5_cas_commit", 32'(qv), 32'(8'h22));
    we[0] = 1'b1; a[0] = 16'h0010; ds[0] = 2'b01; d[0] = 16'h3333; req[0] = !req[0];
    tick(3);
    rst[0] = 1'b1;
    #1;
    chk("c5_act_busy", 32'(busy[0]), 32'(1'b0));
    @(negedge clk);
    req[0] = 1'b0; rst[0] = 1'b0;
    access(0, 1'b0, 16'h0010, 2'b00, 16'h0000, qv);
    chk("c5_act_nocommit", 32'(qv), 32'(8'h22));

    // Back-to-back random traffic against a byte model.
    for (int w = 0; w < 32; w++) begin
      b = 8'(w * 7 + 3);
      access(0, 1'b1, 16'(2 * w), 2'b11, {b, b}, qv);
      mdl[2*w] = b; mdl[2*w+1] = b;
    end
    for (int k = 0; k < 256; k++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 16'($urandom_range(0, 63));
      be   = 2'($urandom_range(0, 3));
      b    = 8'($urandom_range(0, 255));
      access(0, wr, addr, be, {b, b}, qv);
      if (wr) begin
        if (be[0]) mdl[{addr[5:1], 1'b0}] = b;
        if (be[1]) mdl[{addr[5:1], 1'b1}] = b;
      end else begin
        chk("rnd_q", 32'(qv), 32'(mdl[addr[5:0]]));
      end
    end
    tick(12);
    chk("rnd_no_extra", 32'(ack[0]), 32'(req[0]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
